// File: rtl/dsp_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// dsp_issue_ctrl_if
//   Bundle between the instruction decoder and the DSP issue controller.
//
//   Decoder -> controller : in_valid, in_rd, in_rs1, in_rs2,
//                           in_reg_write, in_mac_enable, in_simd_enable
//   Controller -> decoder : in_ready (combinational accept)
//   Controller -> units   : issue_valid, issue_unit, issue_rd
//   Controller -> RF      : wb_valid, wb_unit, wb_rd
//   Status                : busy
//
//   Unit encoding on issue_unit / wb_unit: 00 ALU, 01 MAC, 10 SIMD.
//   Modports: master = decoder/environment side, slave = controller side.
// -----------------------------------------------------------------------------
interface dsp_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic       in_reg_write;
  logic       in_mac_enable;
  logic       in_simd_enable;

  logic       issue_valid;
  logic [1:0] issue_unit;
  logic [4:0] issue_rd;

  logic       wb_valid;
  logic [1:0] wb_unit;
  logic [4:0] wb_rd;

  logic       busy;

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2,
           in_reg_write, in_mac_enable, in_simd_enable,
    input  in_ready, issue_valid, issue_unit, issue_rd,
           wb_valid, wb_unit, wb_rd, busy
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2,
           in_reg_write, in_mac_enable, in_simd_enable,
    output in_ready, issue_valid, issue_unit, issue_rd,
           wb_valid, wb_unit, wb_rd, busy
  );
endinterface

// File: rtl/dsp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// dsp_issue_ctrl
//   Single-issue dispatch controller for an ALU / MAC / SIMD datapath.
//   Accepts one decoded instruction per cycle when no hazard exists, strobes
//   it to the selected unit one cycle later, and produces the register-file
//   writeback strobe when the unit's fixed latency has elapsed.
//
//   Hazard tracking:
//     - 32-bit pending mask (scoreboard) for RAW/WAW, no bypass.
//     - Non-pipelined MAC guarded by a busy counter.
//     - 8-entry writeback reservation shift register so that two units never
//       write back in the same cycle; it also carries the rd/unit tag of each
//       reserved writeback.
//
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous, active-high reset
//     flush - synchronous abort of all in-flight work
//     bus   - dsp_issue_ctrl_if.slave (decoder handshake, issue, writeback)
//
//   Parameters:
//     MAC_LAT  - MAC latency, issue handshake to writeback (2..7)
//     SIMD_LAT - SIMD latency, issue handshake to writeback (1..7)
// -----------------------------------------------------------------------------
module dsp_issue_ctrl #(
  parameter int unsigned MAC_LAT  = 3,
  parameter int unsigned SIMD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  dsp_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    UNIT_ALU  = 2'b00,
    UNIT_MAC  = 2'b01,
    UNIT_SIMD = 2'b10
  } unit_e;

  localparam logic [2:0] ALU_L  = 3'd1;
  localparam logic [2:0] MAC_L  = 3'(MAC_LAT);
  localparam logic [2:0] SIMD_L = 3'(SIMD_LAT);

  // Architectural state
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic [7:0]  resv;        // resv[k]: a writeback leaves at (now + 1 + k)
  logic [7:0]  resv_next;
  logic [2:0]  mac_cnt;
  logic [2:0]  mac_cnt_next;
  logic [4:0]  tag_rd   [8];
  unit_e       tag_unit [8];

  // Output registers
  logic        issue_valid_q;
  unit_e       issue_unit_q;
  logic [4:0]  issue_rd_q;
  logic        wb_valid_q;
  unit_e       wb_unit_q;
  logic [4:0]  wb_rd_q;

  // Decode of the presented instruction
  unit_e       sel_unit;
  logic [2:0]  sel_lat;
  logic [2:0]  wr_idx;
  logic        raw_ok;
  logic        waw_ok;
  logic        mac_ok;
  logic        slot_ok;
  logic        ready;
  logic        hs;
  logic        hs_wr;

  // ---------------------------------------------------------------------------
  // Unit select: MAC wins over SIMD, ALU is the fallback.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel_unit = UNIT_ALU;
    sel_lat  = ALU_L;
    if (bus.in_mac_enable) begin
      sel_unit = UNIT_MAC;
      sel_lat  = MAC_L;
    end else if (bus.in_simd_enable) begin
      sel_unit = UNIT_SIMD;
      sel_lat  = SIMD_L;
    end
  end

  // The reservation is checked at index L (writeback at T+1+L as seen now)
  // but written at L-1 because the register shifts down on the same edge.
  assign wr_idx = sel_lat - 3'd1;

  // ---------------------------------------------------------------------------
  // Accept logic. Independent of in_valid so the decoder can look ahead.
  // ---------------------------------------------------------------------------
  assign raw_ok  = !pending[bus.in_rs1] && !pending[bus.in_rs2];
  assign waw_ok  = !bus.in_reg_write || !pending[bus.in_rd];
  assign mac_ok  = (sel_unit != UNIT_MAC) || (mac_cnt == 3'd0);
  assign slot_ok = !bus.in_reg_write || !resv[sel_lat];

  assign ready   = !rst && !flush && raw_ok && waw_ok && mac_ok && slot_ok;
  assign hs      = bus.in_valid && ready;
  assign hs_wr   = hs && bus.in_reg_write;

  // ---------------------------------------------------------------------------
  // Next-state for scoreboard, reservations and MAC counter.
  // A writeback clears its bit at the end of the wb_valid cycle, so a reader
  // sees the register free only on the following cycle (no bypass).
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_next = pending;
    if (wb_valid_q) pending_next[wb_rd_q] = 1'b0;
    if (hs_wr && (bus.in_rd != 5'd0)) pending_next[bus.in_rd] = 1'b1;
    pending_next[0] = 1'b0;

    resv_next = {1'b0, resv[7:1]};
    if (hs_wr) resv_next[wr_idx] = 1'b1;

    // The handshake cycle itself counts as the first MAC busy cycle, so the
    // register holds MAC_LAT after the edge and the next MAC is accepted
    // MAC_LAT+1 cycles after the previous one.
    mac_cnt_next = mac_cnt;
    if (hs && (sel_unit == UNIT_MAC)) mac_cnt_next = MAC_L;
    else if (mac_cnt != 3'd0)         mac_cnt_next = mac_cnt - 3'd1;
  end

  // ---------------------------------------------------------------------------
  // Control state. Reset has priority over flush; both discard in-flight work.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      resv          <= '0;
      mac_cnt       <= '0;
      issue_valid_q <= 1'b0;
      issue_unit_q  <= UNIT_ALU;
      issue_rd_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_unit_q     <= UNIT_ALU;
      wb_rd_q       <= '0;
    end else if (flush) begin
      pending       <= '0;
      resv          <= '0;
      mac_cnt       <= '0;
      issue_valid_q <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      pending       <= pending_next;
      resv          <= resv_next;
      mac_cnt       <= mac_cnt_next;
      issue_valid_q <= hs;
      if (hs) begin
        issue_unit_q <= sel_unit;
        issue_rd_q   <= bus.in_rd;
      end
      wb_valid_q <= resv[0];
      if (resv[0]) begin
        wb_unit_q <= tag_unit[0];
        wb_rd_q   <= tag_rd[0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback tags travel alongside the reservation bits.
  // ---------------------------------------------------------------------------
  // NOTE: the tag array has no reset; an entry is only consumed when its
  // reservation bit is set, and those bits are reset/flushed above.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      tag_rd[i]   <= tag_rd[i+1];
      tag_unit[i] <= tag_unit[i+1];
    end
    if (hs_wr) begin
      tag_rd[wr_idx]   <= bus.in_rd;
      tag_unit[wr_idx] <= sel_unit;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready    = ready;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_unit  = issue_unit_q;
  assign bus.issue_rd    = issue_rd_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_unit     = wb_unit_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.busy        = (pending != '0) || (resv != '0) ||
                           (mac_cnt != 3'd0) || issue_valid_q;

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dsp_issue_ctrl
//   Directed bench for dsp_issue_ctrl with MAC_LAT=3, SIMD_LAT=2.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   2 time units after it, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_dsp_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int n_chk = 0;
  int n_bad = 0;

  dsp_issue_ctrl_if bus ();

  dsp_issue_ctrl #(
    .MAC_LAT  (3),
    .SIMD_LAT (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and let combinational in_ready settle.
  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic wr, input logic mac,
                       input logic simd);
    bus.in_valid       = v;
    bus.in_rd          = rd;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
    bus.in_reg_write   = wr;
    bus.in_mac_enable  = mac;
    bus.in_simd_enable = simd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);

    // ---- Reset ----
    next_cycle();
    next_cycle();
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    idle();
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_issue_unit",  bus.issue_unit,  0);
    check("rst_issue_rd",    bus.issue_rd,    0);
    check("rst_wb_valid",    bus.wb_valid,    0);
    check("rst_wb_unit",     bus.wb_unit,     0);
    check("rst_wb_rd",       bus.wb_rd,       0);
    check("rst_busy",        bus.busy,        0);
    check("rst_ready_after", bus.in_ready,    1);

    // ---- ALU rd=5: issue at T+1, wb at T+2, free at T+3 ----
    next_cycle();
    drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    check("alu_ready", bus.in_ready, 1);
    next_cycle();
    idle();
    check("alu_issue_valid", bus.issue_valid, 1);
    check("alu_issue_unit",  bus.issue_unit,  0);
    check("alu_issue_rd",    bus.issue_rd,    5);
    check("alu_wb_early",    bus.wb_valid,    0);
    check("alu_busy",        bus.busy,        1);
    next_cycle();
    drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    check("alu_wb_valid", bus.wb_valid, 1);
    check("alu_wb_rd",    bus.wb_rd,    5);
    check("alu_wb_unit",  bus.wb_unit,  0);
    check("alu_no_bypass", bus.in_ready, 0);
    next_cycle();
    drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    check("alu_rd_free",   bus.in_ready, 1);
    check("alu_wb_once",   bus.wb_valid, 0);
    check("alu_busy_done", bus.busy,     0);

    // ---- MAC rd=3, dependent ALU rs1=3 held valid ----
    next_cycle();
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("raw_mac_ready", bus.in_ready, 1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      drive(1'b1, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
      check("raw_stall", bus.in_ready, 0);
      if (c == 1) check("raw_mac_unit", bus.issue_unit, 1);
      if (c == 4) begin
        check("raw_mac_wb_valid", bus.wb_valid, 1);
        check("raw_mac_wb_rd",    bus.wb_rd,    3);
        check("raw_mac_wb_unit",  bus.wb_unit,  1);
      end else begin
        check("raw_mac_wb_quiet", bus.wb_valid, 0);
      end
    end
    next_cycle();
    drive(1'b1, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    check("raw_accept", bus.in_ready, 1);
    next_cycle();
    idle();
    check("raw_alu_issue", bus.issue_valid, 1);
    check("raw_alu_rd",    bus.issue_rd,    4);
    next_cycle();
    idle();
    check("raw_alu_wb",    bus.wb_valid, 1);
    check("raw_alu_wb_rd", bus.wb_rd,    4);
    next_cycle();
    idle();
    check("raw_busy_done", bus.busy, 0);

    // ---- Back-to-back MAC (second has simd=1 too, MAC must win) ----
    next_cycle();
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("mac2_first_ready", bus.in_ready, 1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      check("mac2_busy_stall", bus.in_ready, 0);
    end
    next_cycle();
    drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    check("mac2_second_ready", bus.in_ready, 1);
    check("mac2_wb1_valid",    bus.wb_valid, 1);
    check("mac2_wb1_rd",       bus.wb_rd,    1);
    next_cycle();
    idle();
    check("mac2_issue_valid", bus.issue_valid, 1);
    check("mac2_issue_unit",  bus.issue_unit,  1);
    check("mac2_issue_rd",    bus.issue_rd,    2);
    for (int c = 6; c <= 7; c++) begin
      next_cycle();
      idle();
      check("mac2_wb_gap", bus.wb_valid, 0);
    end
    next_cycle();
    idle();
    check("mac2_wb2_valid", bus.wb_valid, 1);
    check("mac2_wb2_rd",    bus.wb_rd,    2);
    check("mac2_wb2_unit",  bus.wb_unit,  1);
    next_cycle();
    idle();
    check("mac2_busy_done", bus.busy, 0);

    // ---- Writeback slot conflict: SIMD rd=6 then ALU rd=7 ----
    next_cycle();
    drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    check("slot_simd_ready", bus.in_ready, 1);
    next_cycle();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("slot_refused",    bus.in_ready,   0);
    check("slot_simd_unit",  bus.issue_unit, 2);
    next_cycle();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("slot_accepted", bus.in_ready, 1);
    check("slot_wb_quiet", bus.wb_valid, 0);
    next_cycle();
    idle();
    check("slot_wb1_valid", bus.wb_valid, 1);
    check("slot_wb1_rd",    bus.wb_rd,    6);
    check("slot_wb1_unit",  bus.wb_unit,  2);
    next_cycle();
    idle();
    check("slot_wb2_valid", bus.wb_valid, 1);
    check("slot_wb2_rd",    bus.wb_rd,    7);
    check("slot_wb2_unit",  bus.wb_unit,  0);
    next_cycle();
    idle();
    check("slot_wb_end", bus.wb_valid, 0);

    // ---- rd=0 still writes back and never blocks WAW ----
    next_cycle();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("rd0_first_ready", bus.in_ready, 1);
    next_cycle();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    check("rd0_waw_ready", bus.in_ready, 1);
    next_cycle();
    idle();
    check("rd0_wb1_valid", bus.wb_valid, 1);
    check("rd0_wb1_rd",    bus.wb_rd,    0);
    check("rd0_wb1_unit",  bus.wb_unit,  0);
    next_cycle();
    idle();
    check("rd0_wb_gap", bus.wb_valid, 0);
    next_cycle();
    idle();
    check("rd0_wb2_valid", bus.wb_valid, 1);
    check("rd0_wb2_unit",  bus.wb_unit,  2);

    // ---- MAC without reg_write: occupies MAC only ----
    next_cycle();
    drive(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("nowr_mac_ready", bus.in_ready, 1);
    next_cycle();
    drive(1'b1, 5'd12, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
    check("nowr_no_scoreboard", bus.in_ready,   1);
    check("nowr_issue_valid",   bus.issue_valid, 1);
    check("nowr_issue_rd",      bus.issue_rd,    10);
    next_cycle();
    drive(1'b0, 5'd11, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("nowr_mac_busy",  bus.in_ready, 0);
    check("nowr_wb_quiet",  bus.wb_valid, 0);
    next_cycle();
    idle();
    check("nowr_alu_wb",    bus.wb_valid, 1);
    check("nowr_alu_wb_rd", bus.wb_rd,    12);
    next_cycle();
    idle();
    check("nowr_no_mac_wb", bus.wb_valid, 0);
    check("nowr_busy_done", bus.busy,     0);

    // ---- Flush kills pending MAC and an ALU wb due at F+1 ----
    next_cycle();
    drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("flush_mac_ready", bus.in_ready, 1);
    next_cycle();
    drive(1'b1, 5'd20, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("flush_alu_ready", bus.in_ready, 1);
    next_cycle();
    flush = 1'b1;
    drive(1'b1, 5'd13, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    check("flush_ready_low", bus.in_ready, 0);
    next_cycle();
    flush = 1'b0;
    drive(1'b1, 5'd13, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    check("flush_busy_clear", bus.busy,        0);
    check("flush_issue_low",  bus.issue_valid, 0);
    check("flush_wb_killed",  bus.wb_valid,    0);
    check("flush_rs1_free",   bus.in_ready,    1);
    next_cycle();
    idle();
    check("flush_no_mac_wb",  bus.wb_valid,    0);
    check("flush_new_issue",  bus.issue_valid, 1);
    check("flush_new_rd",     bus.issue_rd,    13);
    next_cycle();
    idle();
    check("flush_new_wb",     bus.wb_valid, 1);
    check("flush_new_wb_rd",  bus.wb_rd,    13);

    // ---- Reset mid-operation with three ops in flight ----
    next_cycle();
    drive(1'b1, 5'd14, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("mrst_op1_ready", bus.in_ready, 1);
    next_cycle();
    drive(1'b1, 5'd15, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("mrst_op2_ready", bus.in_ready, 1);
    next_cycle();
    drive(1'b1, 5'd16, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    check("mrst_op3_ready", bus.in_ready, 1);
    next_cycle();
    rst   = 1'b1;
    flush = 1'b1;
    drive(1'b1, 5'd17, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("mrst_ready_low", bus.in_ready, 0);
    next_cycle();
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    check("mrst_issue_valid", bus.issue_valid, 0);
    check("mrst_issue_unit",  bus.issue_unit,  0);
    check("mrst_issue_rd",    bus.issue_rd,    0);
    check("mrst_wb_valid",    bus.wb_valid,    0);
    check("mrst_wb_unit",     bus.wb_unit,     0);
    check("mrst_wb_rd",       bus.wb_rd,       0);
    check("mrst_busy",        bus.busy,        0);
    for (int c = 5; c <= 8; c++) begin
      next_cycle();
      idle();
      check("mrst_no_late_wb", bus.wb_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
